// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity encodings, TX state
// encodings and sizing helpers used by the FIFO and the transmitter.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;
  localparam logic [1:0] PARITY_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data, occupancy count and a
// synchronous flush driven by the reset input.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = fifo_count_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a valid/ready push into an internal FIFO; frame
// format and baud divisor are captured per frame when the word is popped.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  localparam int CW = fifo_count_width(FIFO_DEPTH)
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  // Handshake: a word is accepted on a rising edge where DATA_VALID and
  // DATA_READY are both high; DATA_READY depends only on FIFO fullness.
  input  logic [WORD_SIZE-1:0] DATA_BUS,
  input  logic                 DATA_VALID,
  output logic                 DATA_READY,
  input  logic [DIV_WIDTH-1:0] BAUD_DIV,
  input  logic [1:0]           PARITY_MODE,
  input  logic                 STOP_BITS,
  output logic                 SERIAL_OUT,
  output logic                 BUSY,
  output logic [CW-1:0]        FIFO_COUNT,
  output tx_state_e            STATE_DBG
);

  localparam int BW = $clog2(WORD_SIZE);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

  logic [WORD_SIZE-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  tx_state_e            state_q;
  logic [DIV_WIDTH-1:0] baud_cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [BW-1:0]        bit_idx_q;
  logic [WORD_SIZE-1:0] word_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 two_stop_q;
  logic                 serial_q;
  logic                 serial_d;
  logic                 bit_end;

  uart_sync_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .push_i  (DATA_VALID),
    .wdata_i (DATA_BUS),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (FIFO_COUNT)
  );

  assign DATA_READY = !fifo_full;
  assign BUSY       = (state_q != ST_IDLE);
  assign SERIAL_OUT = serial_q;
  assign STATE_DBG  = state_q;

  // A pop happens from IDLE or at the very end of the last stop bit, which
  // is what makes back-to-back frames gap-free.
  always_comb begin
    bit_end  = (baud_cnt_q == div_q);
    fifo_pop = 1'b0;
    if (state_q == ST_IDLE) begin
      fifo_pop = !fifo_empty;
    end else if (state_q == ST_STOP && bit_end && bit_idx_q == BW'(two_stop_q)) begin
      fifo_pop = !fifo_empty;
    end
  end

  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = word_q[bit_idx_q];
      ST_PARITY: serial_d = par_bit_q;
      default:   serial_d = 1'b1;
    endcase
  end

  // The line register follows the state by one clock, so the start bit
  // appears on the pin one edge after the pop.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      word_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
    end else begin
      serial_q <= serial_d;
      if (fifo_pop) begin
        word_q     <= fifo_rdata;
        div_q      <= BAUD_DIV;
        par_en_q   <= parity_enabled(PARITY_MODE);
        par_bit_q  <= (PARITY_MODE == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
        two_stop_q <= STOP_BITS;
      end
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            state_q    <= ST_START;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
          end
        end
        default: begin
          if (!bit_end) begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end else begin
            baud_cnt_q <= '0;
            case (state_q)
              ST_START: begin
                state_q   <= ST_DATA;
                bit_idx_q <= '0;
              end
              ST_DATA: begin
                if (bit_idx_q == LAST_BIT) begin
                  bit_idx_q <= '0;
                  state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                  bit_idx_q <= bit_idx_q + 1'b1;
                end
              end
              ST_PARITY: begin
                state_q   <= ST_STOP;
                bit_idx_q <= '0;
              end
              ST_STOP: begin
                if (bit_idx_q == BW'(two_stop_q)) begin
                  bit_idx_q <= '0;
                  state_q   <= fifo_pop ? ST_START : ST_IDLE;
                end else begin
                  bit_idx_q <= bit_idx_q + 1'b1;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
